// File: rtl/mod_n_seq_checker.sv
// Mod-N sequence checker: tracks an observed mod-N counter, flags breaks, pulses on wrap.
// Define MODN_CHK_STICKY_EN to build the latched err_sticky flag (otherwise tied to 0).
module mod_n_seq_checker #(
   parameter int N        = 16,
   parameter int WIDTH    = $clog2(N),
   parameter int LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] count,
   output logic             locked,
   output logic             err,
   output logic             wrap,
   output logic [WIDTH-1:0] expected,
   output logic [7:0]       err_cnt,
   output logic             err_sticky
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACQ    = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [WIDTH:0]   LIM  = (WIDTH+1)'(N);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
   localparam logic [3:0]       LCK  = 4'(LOCK_CNT);

   state_t           r_state;
   state_t           w_state_nx;
   logic [WIDTH-1:0] r_exp;
   logic [WIDTH-1:0] w_exp_nx;
   logic [3:0]       r_run;
   logic [3:0]       w_run_nx;
   logic [3:0]       w_run_inc;
   logic             r_locked;
   logic             w_locked_nx;
   logic             r_err;
   logic             w_err_nx;
   logic             r_wrap;
   logic             w_wrap_nx;
   logic [7:0]       r_err_cnt;
   logic             w_oor;
   logic             w_match;
   logic [WIDTH-1:0] w_succ;

   assign w_oor     = ({1'b0, count} >= LIM);
   assign w_match   = (count == r_exp);
   assign w_succ    = (count == LAST) ? '0 : count + WIDTH'(1);
   assign w_run_inc = r_run + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_exp     <= '0;
         r_run     <= '0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
         r_wrap    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_exp    <= w_exp_nx;
         r_run    <= w_run_nx;
         r_locked <= w_locked_nx;
         r_err    <= w_err_nx;
         r_wrap   <= w_wrap_nx;
         if (w_err_nx && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_exp_nx    = r_exp;
      w_run_nx    = r_run;
      w_locked_nx = r_locked;
      w_err_nx    = 1'b0;
      w_wrap_nx   = 1'b0;
      if (en) begin
         if (w_oor) begin
            w_err_nx    = 1'b1;
            w_state_nx  = S_IDLE;
            w_locked_nx = 1'b0;
            w_exp_nx    = '0;
            w_run_nx    = '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  w_exp_nx   = w_succ;
                  w_run_nx   = '0;
                  w_state_nx = S_ACQ;
               end
               S_ACQ: begin
                  w_exp_nx = w_succ;
                  if (w_match) begin
                     w_run_nx = w_run_inc;
                     if (w_run_inc == LCK) begin
                        w_state_nx  = S_LOCKED;
                        w_locked_nx = 1'b1;
                     end
                  end else begin
                     w_run_nx = '0;
                  end
               end
               S_LOCKED: begin
                  w_exp_nx = w_succ;
                  if (w_match) begin
                     w_wrap_nx = (count == '0);
                  end else begin
                     w_err_nx    = 1'b1;
                     w_locked_nx = 1'b0;
                     w_state_nx  = S_ACQ;
                     w_run_nx    = '0;
                  end
               end
               default: begin
                  w_state_nx  = S_IDLE;
                  w_locked_nx = 1'b0;
                  w_exp_nx    = '0;
                  w_run_nx    = '0;
               end
            endcase
         end
      end
   end

   assign locked   = r_locked;
   assign err      = r_err;
   assign wrap     = r_wrap;
   assign expected = r_exp;
   assign err_cnt  = r_err_cnt;

`ifdef MODN_CHK_STICKY_EN
   logic r_sticky;

   // Sets on the same edge that raises err, so it is visible with the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_sticky <= 1'b0;
      else if (w_err_nx)
         r_sticky <= 1'b1;
   end

   assign err_sticky = r_sticky;
`else
   assign err_sticky = 1'b0;
`endif

endmodule

// File: doc/mod_n_seq_checker.md
MOD_N_SEQ_CHECKER -- requirements
Module: mod_n_seq_checker

Interface
REQ-001 Parameter N, default 16: modulus of the observed counter; legal range N >= 2.
REQ-002 Parameter WIDTH, default $clog2(N): bit width of the count input and the expected output.
REQ-003 Parameter LOCK_CNT, default 4: number of consecutive correct steps required to declare lock; legal range 1..15.
REQ-004 clk  input  1  rising-edge clock, one clock domain; the block SHALL use a single clock.
REQ-005 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-006 en  input  1  sample qualifier; count is sampled only on edges where en=1.
REQ-007 count  input  WIDTH  value driven by the mod-N counter under observation.
REQ-008 locked  output  1  high while the observed sequence is tracked.
REQ-009 err  output  1  one-cycle error pulse.
REQ-010 wrap  output  1  one-cycle pulse on an observed N-1 -> 0 step while LOCKED.
REQ-011 expected  output  WIDTH  value predicted for the next sample.
REQ-012 err_cnt  output  8  saturating error counter.
REQ-013 err_sticky  output  1  latched error flag (see Configuration).

Function
REQ-014 The block SHALL implement three states: IDLE, ACQ and LOCKED.
REQ-015 All outputs SHALL be registered and SHALL update on the edge at which the sample is taken.
REQ-016 The block SHALL compute the successor of a value v as succ(v) = 0 when v == N-1, and v+1 otherwise.
REQ-017 On an edge with en=0, the block SHALL hold all state, counters and expected, and SHALL drive err=0 and wrap=0.
REQ-018 On any en=1 sample with count >= N, in any state: err SHALL pulse, err_cnt SHALL increment, state SHALL go to IDLE, locked SHALL clear, and expected SHALL be 0.
REQ-019 In IDLE, on a valid in-range sample: prev SHALL load count, expected SHALL load succ(count), the run counter SHALL load 0, and state SHALL go to ACQ.
REQ-020 In ACQ, when count == expected: run SHALL increment; on reaching LOCK_CNT, state SHALL go to LOCKED and locked SHALL be set on that same edge.
REQ-021 In ACQ, when count != expected: run SHALL load 0, expected SHALL load succ(count), and err SHALL NOT pulse.
REQ-022 In LOCKED, when count == expected: expected SHALL load succ(count); wrap SHALL pulse if count == 0 and N > 1.
REQ-023 In LOCKED, when count != expected (for example, the observed counter was reset mid-sequence): err SHALL pulse, err_cnt SHALL increment, locked SHALL clear, state SHALL go to ACQ with run=0, and expected SHALL load succ(count).
REQ-024 err_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-025 err and wrap SHALL never be high on the same cycle.

Reset
REQ-026 While rst=1, the block SHALL hold state=IDLE, run=0, and locked, err, wrap, expected, err_cnt and err_sticky all at 0, independent of clk.
REQ-027 On the first rising edge after rst deasserts, the block SHALL evaluate samples normally under the IDLE rules.

Configuration
REQ-028 When macro MODN_CHK_STICKY_EN is defined, err_sticky SHALL set on any cycle where err=1 and SHALL clear only on rst.
REQ-029 When MODN_CHK_STICKY_EN is undefined, the err_sticky port SHALL remain present and SHALL be tied to 0; no sticky register SHALL be synthesised.

Verification
REQ-030 N=16, LOCK_CNT=4, en=1, count free-running from 0 after reset:
- locked SHALL be 1 from the edge sampling count=4.
- wrap SHALL pulse on every 15->0 step.
- err_cnt SHALL stay at 0.
REQ-031 While locked, inject count sequence 6,7,0 (observed counter reset):
- err SHALL pulse on the edge sampling 0.
- err_cnt SHALL become 1 and locked SHALL clear.
- locked SHALL reassert at the sample of count=4.
REQ-032 While locked, hold en=0 for 3 cycles with count frozen at 9, then resume at 10:
- err SHALL stay 0 and locked SHALL stay 1.
- expected SHALL hold 10 throughout.
REQ-033 N=10, WIDTH=4, while locked, drive count=12:
- err SHALL pulse, err_cnt SHALL increment and state SHALL return to IDLE.
- The next valid 0,1,2,3,4 sequence SHALL relock.
REQ-034 Drive 300 consecutive out-of-range samples: err_cnt SHALL reach 255 and SHALL stay at 255; assert rst mid-run and err_cnt SHALL drop to 0 without a clock edge.
REQ-035 Single injected error, run twice:
- With MODN_CHK_STICKY_EN defined: err_sticky SHALL stay 1 until rst.
- With MODN_CHK_STICKY_EN undefined: err_sticky SHALL stay 0.
